// File: rtl/ibuf_rc_hl.sv
// Per-VC input flit buffer ahead of route computation: FIFO, head detection, rc_en pulse, credit return.
// Optional macro IBUF_BYPASS_EN: a head arriving into an empty idle buffer triggers rc_en in the same cycle.
module ibuf_rc_hl #(
   parameter int DEPTH    = 4,
   parameter int PTRW     = 2,
   parameter int DATAW    = 64,
   parameter int HEAD_BIT = 63,
   parameter int TAIL_BIT = 62
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [DATAW-1:0] idata,
   input  logic             ivalid,
   output logic             ordy,
   output logic [DATAW-1:0] rc_data,
   output logic             rc_en,
   output logic [DATAW-1:0] odata,
   output logic             ovalid,
   input  logic             oready,
   output logic             credit_out,
   output logic [1:0]       state,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUTE  = 2'd1,
      ACTIVE = 2'd2
   } state_e;

   localparam logic [PTRW:0] FULL_COUNT = (PTRW+1)'(DEPTH);

   state_e           state_q, state_d;
   logic [DATAW-1:0] mem_q [DEPTH];
   logic [PTRW-1:0]  wrPtr_q, rdPtr_q;
   logic [PTRW:0]    count_q, count_d;
   logic [DATAW-1:0] rcData_q;
   logic             credit_q, err_q;

   logic             empty, push, pop, orphan, overflow, rcEn, popOk;
   logic [DATAW-1:0] front, rcBus;

   assign empty    = (count_q == '0);
   assign front    = empty ? '0 : mem_q[rdPtr_q];
   assign ordy     = (count_q != FULL_COUNT);
   assign push     = ivalid & ordy;
   assign overflow = ivalid & ~ordy;

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      orphan  = 1'b0;
      rcEn    = 1'b0;
      rcBus   = front;
      popOk   = 1'b0;
      case (state_q)
         IDLE: begin
`ifdef IBUF_BYPASS_EN
            if (empty && ivalid && idata[HEAD_BIT]) begin
               rcEn    = 1'b1;
               rcBus   = idata;
               state_d = ACTIVE;
            end else
`endif
            if (!empty) begin
               if (front[HEAD_BIT]) begin
                  state_d = ROUTE;
               end else begin
                  // A non-head flit with no open packet can never be routed; drain it.
                  pop    = 1'b1;
                  orphan = 1'b1;
               end
            end
         end
         ROUTE: begin
            rcEn    = 1'b1;
            state_d = ACTIVE;
         end
         ACTIVE: begin
            popOk = ~empty;
            if (popOk && oready) begin
               pop = 1'b1;
               if (front[TAIL_BIT]) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wrPtr_q] <= idata;
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q  <= IDLE;
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         count_q  <= '0;
         rcData_q <= '0;
         credit_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wrPtr_q  <= wrPtr_q + PTRW'(push);
         rdPtr_q  <= rdPtr_q + PTRW'(pop);
         count_q  <= count_d;
         credit_q <= pop;
         if (overflow || orphan) err_q <= 1'b1;
         // Downstream latches on rc_en, so hold the last presented head in between.
         if (rcEn) rcData_q <= rcBus;
      end
   end

   assign rc_en      = rcEn;
   assign rc_data    = rcEn ? rcBus : rcData_q;
   assign odata      = front;
   assign ovalid     = popOk;
   assign credit_out = credit_q;
   assign state      = state_q;
   assign err        = err_q;

endmodule

// File: tb/tb_ibuf_rc_hl.sv
// Scoreboard bench for ibuf_rc_hl: expected flits and route heads are queued as stimulus is driven.
module tb_ibuf_rc_hl;

   logic        clk = 1'b0;
   logic        rst_ = 1'b1;
   logic [63:0] idata = '0;
   logic        ivalid = 1'b0;
   logic        oready = 1'b0;
   logic        ordy, rc_en, ovalid, credit_out, err;
   logic [63:0] rc_data, odata;
   logic [1:0]  state;

   int compared = 0;
   int mismatched = 0;
   int cycleCnt = 0;
   int creditCnt = 0;
   int rcCount = 0;
   int lastRcCycle = -100;
   int prevRcCycle = -100;
   logic [63:0] dataQ[$];
   logic [63:0] rcQ[$];

   ibuf_rc_hl dut (
      .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ordy(ordy),
      .rc_data(rc_data), .rc_en(rc_en), .odata(odata), .ovalid(ovalid),
      .oready(oready), .credit_out(credit_out), .state(state), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt++;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Scoreboard monitor: pops expectations whenever the DUT produces a route head or a flit.
   always @(negedge clk) begin
      if (!rst_) begin
         if (rc_en) begin
            rcCount++;
            prevRcCycle = lastRcCycle;
            lastRcCycle = cycleCnt;
            if (rcQ.size() == 0) checkOutput("rc_unexpected", 1, 0);
            else checkOutput("rc_data", rc_data, rcQ.pop_front());
         end
         if (ovalid && oready) begin
            if (dataQ.size() == 0) checkOutput("pop_unexpected", 1, 0);
            else checkOutput("odata", odata, dataQ.pop_front());
         end
         if (credit_out) creditCnt++;
         if (state == 2'd1) checkOutput("ovalid_in_route", ovalid, 0);
      end
   end

   task automatic applyStimulus(input logic v, input logic [63:0] d);
      @(posedge clk);
      #1;
      ivalid = v;
      idata  = d;
   endtask

   task automatic sendFlit(input logic [63:0] d, input bit deliver);
      applyStimulus(1'b1, d);
      if (deliver) begin
         dataQ.push_back(d);
         if (d[63]) rcQ.push_back(d);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 64'h0);
   endtask

   task automatic waitState(input string tag, input logic [1:0] target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (state == target) break;
         @(posedge clk);
         #1;
      end
      checkOutput(tag, state, target);
   endtask

   task automatic doReset();
      rst_ = 1'b1;
      ivalid = 1'b0;
      idata = '0;
      oready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      dataQ.delete();
      rcQ.delete();
      checkOutput("rst_state", state, 0);
      checkOutput("rst_ovalid", ovalid, 0);
      checkOutput("rst_rc_en", rc_en, 0);
      checkOutput("rst_credit", credit_out, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_odata", odata, 0);
      rst_ = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst_ordy", ordy, 1);
   endtask

   initial begin
      int headCyc, c0, r0, expLat;
`ifdef IBUF_BYPASS_EN
      expLat = 0;
`else
      expLat = 2;
`endif
      doReset();

      // 3-flit packet streamed straight through
      oready = 1'b1;
      c0 = creditCnt;
      r0 = rcCount;
      sendFlit(64'h8000_0000_0000_0001, 1);
      headCyc = cycleCnt;
      sendFlit(64'h0000_0000_0000_0002, 1);
      sendFlit(64'h4000_0000_0000_0003, 1);
      idle(10);
      checkOutput("t1_rc_latency", lastRcCycle - headCyc, expLat);
      checkOutput("t1_rc_count", rcCount - r0, 1);
      checkOutput("t1_credits", creditCnt - c0, 3);
      checkOutput("t1_state", state, 0);
      checkOutput("t1_ovalid", ovalid, 0);

      // Back-to-back single-flit packets
      c0 = creditCnt;
      r0 = rcCount;
      sendFlit(64'hC000_0000_0000_0011, 1);
      sendFlit(64'hC000_0000_0000_0012, 1);
      idle(12);
      checkOutput("t3_rc_count", rcCount - r0, 2);
      checkOutput("t3_rc_gap_ge3", ((lastRcCycle - prevRcCycle) >= 3), 1);
      checkOutput("t3_credits", creditCnt - c0, 2);
      checkOutput("t3_state", state, 0);

      // Orphan body flit in IDLE
      checkOutput("t4_err_before", err, 0);
      c0 = creditCnt;
      r0 = rcCount;
      sendFlit(64'h0000_0000_0000_0021, 0);
      idle(5);
      checkOutput("t4_rc_count", rcCount - r0, 0);
      checkOutput("t4_credits", creditCnt - c0, 1);
      checkOutput("t4_err", err, 1);
      checkOutput("t4_state", state, 0);

      // Reset while ACTIVE with two flits buffered
      oready = 1'b0;
      sendFlit(64'h8000_0000_0000_0031, 1);
      sendFlit(64'h0000_0000_0000_0032, 1);
      applyStimulus(1'b0, 64'h0);
      waitState("t5_reach_active", 2'd2, 10);
      checkOutput("t5_ovalid_before", ovalid, 1);
      rst_ = 1'b1;
      dataQ.delete();
      c0 = creditCnt;
      @(posedge clk);
      #1;
      checkOutput("t5_state", state, 0);
      checkOutput("t5_ovalid", ovalid, 0);
      checkOutput("t5_ordy", ordy, 1);
      checkOutput("t5_err", err, 0);
      rst_ = 1'b0;
      idle(4);
      checkOutput("t5_credits", creditCnt - c0, 0);

      // Overflow: five flits into a four-entry buffer with the switch stalled
      c0 = creditCnt;
      sendFlit(64'h8000_0000_0000_0041, 1);
      sendFlit(64'h0000_0000_0000_0042, 1);
      sendFlit(64'h0000_0000_0000_0043, 1);
      sendFlit(64'h4000_0000_0000_0044, 1);
      sendFlit(64'h0000_0000_0000_0045, 0);
      checkOutput("t2_ordy_full", ordy, 0);
      checkOutput("t2_err_before", err, 0);
      applyStimulus(1'b0, 64'h0);
      checkOutput("t2_err", err, 1);
      checkOutput("t2_ordy_still_full", ordy, 0);
      oready = 1'b1;
      idle(10);
      checkOutput("t2_credits", creditCnt - c0, 4);
      checkOutput("t2_state", state, 0);
      checkOutput("t2_ordy_after", ordy, 1);

`ifdef IBUF_BYPASS_EN
      // Bypass: head into an empty idle buffer is routed the same cycle
      applyStimulus(1'b1, 64'h8000_0000_0000_0051);
      dataQ.push_back(64'h8000_0000_0000_0051);
      rcQ.push_back(64'h8000_0000_0000_0051);
      #1;
      checkOutput("t6_rc_en", rc_en, 1);
      checkOutput("t6_rc_data", rc_data, 64'h8000_0000_0000_0051);
      applyStimulus(1'b0, 64'h0);
      checkOutput("t6_state", state, 2);
      sendFlit(64'h4000_0000_0000_0052, 1);
      idle(8);
      checkOutput("t6_state_end", state, 0);
`endif

      checkOutput("sb_data_drained", dataQ.size(), 0);
      checkOutput("sb_rc_drained", rcQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ibuf_rc_hl.md
Name: ibuf_rc_hl

Overview:
Per-input-VC flit buffer that sits directly upstream of the hybrid unicast/multicast route-computation stage (rtcomp_hl).
- Stores incoming flits in a FIFO.
- Detects when a head flit reaches the front and fires a one-cycle route-compute enable carrying that head flit.
- Forwards body and tail flits to the switch on request.
- Returns one credit per popped flit.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
PTRW, 2, log2(DEPTH)
DATAW, 64, flit width in bits
HEAD_BIT, 63, bit index of head-flit flag inside a flit
TAIL_BIT, 62, bit index of tail-flit flag inside a flit

Ports:
clk  in  1  clock, all state updates on rising edge
rst_  in  1  reset, synchronous, active-high
idata  in  DATAW  incoming flit
ivalid  in  1  idata valid this cycle
ordy  out  1  buffer not full
rc_data  out  DATAW  head flit presented to route computation (rtcomp_hl bdata0)
rc_en  out  1  one-cycle route-compute trigger (rtcomp_hl en)
odata  out  DATAW  flit at FIFO front
ovalid  out  1  odata may be popped
oready  in  1  switch pops front flit when ovalid&oready
credit_out  out  1  one-cycle pulse per popped flit
state  out  2  FSM state: 0 IDLE, 1 ROUTE, 2 ACTIVE
err  out  1  sticky protocol/overflow error

Behaviour:
Reset (rst_=1 at a clock edge):
- Pointers and count cleared, FSM→IDLE, err=0.
- rc_en=0, ovalid=0, credit_out=0.
- odata and rc_data = 0 while empty.
- ordy=1 from the cycle after reset.
- Reset mid-packet discards all buffered flits; no credits are returned for them.

FIFO:
- count is PTRW+1 bits; pointers wrap modulo DEPTH.
- ordy = (count != DEPTH).
- Push when ivalid & ordy.
- Push while full (ivalid & !ordy): flit dropped, err set.
- Simultaneous push and pop when full is not accepted, since ordy is already low.
- Simultaneous push and pop when not full: count unchanged, both take effect.
- A pushed flit is visible at the front the next cycle, not the same cycle.

FSM:
- IDLE, front empty: stay.
- IDLE, front non-empty with HEAD_BIT=1: →ROUTE.
- IDLE, front non-empty with HEAD_BIT=0: orphan flit. Dropped (internal pop, credit_out pulses), err set, stay IDLE.
- ROUTE: rc_en=1 for exactly this one cycle, rc_data=front flit. Always →ACTIVE next cycle.
- ACTIVE: ovalid = !empty; odata = front flit.
  - Pop on ovalid&oready; credit_out=1 the cycle after each pop (registered).
  - Pop of a flit with TAIL_BIT=1: →IDLE.
  - Head+tail single-flit packet: its one pop returns to IDLE.
- After a tail pop, the earliest next rc_en is 2 cycles later (IDLE cycle, then ROUTE).
- ovalid=0 in IDLE and ROUTE; the head flit is only poppable in ACTIVE.
- ACTIVE with empty FIFO (packet body still arriving): ovalid=0, hold state.

rc_data holds its last value outside ROUTE; rtcomp_hl latches on en.

Optional Feature:
IBUF_BYPASS_EN.
- Defined: when the FSM is in IDLE, the FIFO is empty and ivalid&HEAD_BIT arrive, rc_en=1 the same cycle with rc_data=idata. The flit is still pushed, and the FSM goes straight to ACTIVE, skipping ROUTE. Head-to-rc_en latency = 0 cycles.
- Undefined: head-to-rc_en latency = 2 cycles (push, IDLE→ROUTE) via the normal path.

Test Plan:
1. Reset, then push 3-flit packet (head 0x8000..01, body, tail 0x4000..03) → rc_en one pulse with rc_data=0x8000..01 two cycles after head push; 3 pops with oready=1, 3 credit_out pulses; state returns to 0.
2. Push 5 flits into DEPTH=4 with oready=0 → ordy low after 4th, 5th dropped, err=1, count=4.
3. Two back-to-back single-flit packets (HEAD+TAIL bits both set) → exactly two rc_en pulses, separated by ≥3 cycles; ovalid never high in ROUTE.
4. Body flit (no HEAD_BIT) pushed in IDLE → no rc_en, one credit_out, err=1, state stays 0.
5. Assert rst_ in ACTIVE with 2 flits buffered → next cycle state=0, ovalid=0, ordy=1, no credits.
6. IBUF_BYPASS_EN defined, empty IDLE, head pushed → rc_en=1 same cycle with rc_data=idata; state=2 next cycle.
